// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame constants and baud timing helper.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_FRAME_BITS = 10;
   function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; full and empty come from the occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_fifo_transmitter.sv
// uart_fifo_transmitter: FIFO-buffered 8N1 UART transmitter; queued bytes go out back to back.
module uart_fifo_transmitter
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  data_in,
   input  logic                        data_in_valid,
   output logic                        data_in_ready,
   output logic                        serial_out,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
   localparam int CW = $clog2(SET + 1);
   tx_state_t state;
   logic [CW-1:0] sym_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift, head;
   logic full, empty, pop, sym_last;
   assign sym_last = sym_cnt == CW'(SET - 1);
   assign pop = !empty && (state == IDLE || (state == STOP && sym_last));
   assign data_in_ready = !rst && !full;
   assign tx_busy = state != IDLE || fifo_count != '0;
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk),
      .rst(rst),
      .push(data_in_valid && data_in_ready),
      .pop(pop),
      .wr_data(data_in),
      .rd_data(head),
      .full(full),
      .empty(empty),
      .count(fifo_count)
   );
   // A pop always launches a fresh start bit, whether from IDLE or the end of STOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sym_cnt <= '0;
         bit_cnt <= '0;
         shift <= '0;
         serial_out <= 1'b1;
      end else if (pop) begin
         state <= START;
         sym_cnt <= '0;
         bit_cnt <= '0;
         shift <= head;
         serial_out <= 1'b0;
      end else if (state != IDLE) begin
         sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
         if (sym_last)
            case (state)
               START: begin
                  state <= DATA;
                  serial_out <= shift[0];
               end
               DATA:
                  if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                     state <= STOP;
                     serial_out <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shift <= shift >> 1;
                     serial_out <= shift[1];
                  end
               default: begin
                  state <= IDLE;
                  serial_out <= 1'b1;
               end
            endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// tb_uart_fifo_transmitter: directed tests checked per cycle against a queue/frame-position model.
module tb_uart_fifo_transmitter;
   localparam int SET = 10;
   localparam int FRAME = 10 * SET;
   localparam int DEPTH = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] data_in = '0, d_data = '0;
   logic data_in_valid = 1'b0, d_valid = 1'b0;
   logic data_in_ready, serial_out, tx_busy, d_ready, d_serial, d_busy;
   logic [3:0] fifo_count, d_count;
   always #5 clk = ~clk;
   uart_fifo_transmitter #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .serial_out(serial_out), .tx_busy(tx_busy), .fifo_count(fifo_count)
   );
   uart_fifo_transmitter dut_def (
      .clk(clk), .rst(rst), .data_in(d_data), .data_in_valid(d_valid),
      .data_in_ready(d_ready), .serial_out(d_serial), .tx_busy(d_busy), .fifo_count(d_count)
   );
   int total = 0, passed = 0;
   bit chk_en = 1'b0;
   logic [7:0] q[$], rx[$], ex[$];
   logic [7:0] cur, rb;
   bit in_flight = 1'b0, m_push, m_pop;
   int pos = 0;
   logic [9:0] f_a5 = 10'b1101001010, f_3c = 10'b1001111000;
   function automatic bit level(logic [7:0] b, int p);
      int k = p / SET;
      return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
   endfunction
   task automatic check(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
   endtask
   task automatic tick(int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask
   task automatic check_rx(string name);
      check({name, "_count"}, rx.size(), ex.size());
      foreach (ex[i]) check(name, i < rx.size() ? int'(rx[i]) : -1, ex[i]);
   endtask
   // Model: bytes wait in q; a frame is described only by its byte and position within 10 symbols.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         in_flight = 1'b0;
         pos = 0;
      end else begin
         m_push = data_in_valid && q.size() < DEPTH;
         m_pop = 1'b0;
         if (in_flight) begin
            if (pos == FRAME - 1) begin
               if (q.size() != 0) m_pop = 1'b1;
               else in_flight = 1'b0;
            end else pos++;
         end else if (q.size() != 0) m_pop = 1'b1;
         if (m_pop) begin
            cur = q.pop_front();
            pos = 0;
            in_flight = 1'b1;
         end
         if (m_push) q.push_back(data_in);
      end
   end
   always @(negedge clk)
      if (chk_en) begin
         check("serial_out", serial_out, in_flight ? level(cur, pos) : 1);
         check("fifo_count", fifo_count, q.size());
         check("tx_busy", tx_busy, (in_flight || q.size() != 0) ? 1 : 0);
         check("data_in_ready", data_in_ready, (!rst && q.size() < DEPTH) ? 1 : 0);
      end
   // Line decoder: samples mid-symbol and records each received byte.
   initial forever begin
      @(negedge clk);
      if (chk_en && !rst && serial_out === 1'b0) begin
         repeat (SET / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (SET) @(negedge clk);
            rb[i] = serial_out;
         end
         repeat (SET) @(negedge clk);
         rx.push_back(rb);
      end
   end
   initial begin
      tick(3);
      chk_en = 1'b1;
      check("rst_serial", serial_out, 1);
      check("rst_ready", data_in_ready, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_def_serial", d_serial, 1);
      rst = 1'b0;
      tick();
      check("ready_after_rst", data_in_ready, 1);
      tick(5);
      // Single byte 0xA5
      data_in_valid = 1'b1;
      data_in = 8'hA5;
      tick();
      data_in_valid = 1'b0;
      for (int k = 1; k <= FRAME; k++) begin
         tick();
         check("a5_line", serial_out, f_a5[(k-1)/SET]);
      end
      check("a5_busy_last", tx_busy, 1);
      tick();
      check("a5_busy_done", tx_busy, 0);
      ex = {8'hA5};
      check_rx("a5_rx");
      // Back to back
      rx.delete();
      data_in_valid = 1'b1;
      data_in = 8'h55;
      tick();
      data_in = 8'h0F;
      tick();
      data_in_valid = 1'b0;
      tick(230);
      ex = {8'h55, 8'h0F};
      check_rx("b2b_rx");
      // Full FIFO
      rx.delete();
      data_in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         data_in = 8'(i);
         tick();
         if (i == 8) begin
            check("full_count", fifo_count, 8);
            check("full_ready", data_in_ready, 0);
         end
      end
      data_in_valid = 1'b0;
      tick(920);
      ex.delete();
      for (int i = 0; i < 9; i++) ex.push_back(8'(i));
      check_rx("full_rx");
      // Push and pop on the same edge
      rx.delete();
      data_in_valid = 1'b1;
      data_in = 8'h11; tick();
      data_in = 8'h22; tick();
      data_in = 8'h33; tick();
      data_in = 8'h44; tick();
      data_in_valid = 1'b0;
      tick(97);
      check("pp_count_before", fifo_count, 3);
      data_in_valid = 1'b1;
      data_in = 8'h99;
      tick();
      data_in_valid = 1'b0;
      check("pp_count_after", fifo_count, 3);
      check("pp_start", serial_out, 0);
      tick(420);
      ex = {8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
      check_rx("pp_rx");
      // Reset during DATA bit 4
      rx.delete();
      data_in_valid = 1'b1;
      data_in = 8'hC3; tick();
      data_in = 8'h5A; tick();
      data_in = 8'h7E; tick();
      data_in_valid = 1'b0;
      check("mid_count", fifo_count, 2);
      tick(53);
      rst = 1'b1;
      tick();
      check("mid_serial", serial_out, 1);
      check("mid_count_rst", fifo_count, 0);
      check("mid_busy", tx_busy, 0);
      rst = 1'b0;
      for (int k = 0; k < 200; k++) begin
         tick();
         check("mid_line_high", serial_out, 1);
      end
      rx.delete();
      // Default parameters
      d_valid = 1'b1;
      d_data = 8'h3C;
      tick();
      d_valid = 1'b0;
      for (int k = 1; k <= 4340; k++) begin
         tick();
         check("def_line", d_serial, f_3c[(k-1)/434]);
      end
      check("def_busy_last", d_busy, 1);
      tick();
      check("def_busy_done", d_busy, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
